eco32f_decode_sb: RTL and testbench
===================================

ECO32F_DECODE_SB -- requirements
Module: eco32f_decode_sb

Interface
REQ-001 Parameter DEPTH, 4, instruction-queue entries; power of two, >=2.
REQ-002 Parameter LAT_LOAD, 2, scoreboard count loaded for a load writer.
REQ-003 Parameter LAT_MUL, 3, scoreboard count loaded for a mul/div/rem writer.
REQ-004 Parameter LAT_ALU, 1, scoreboard count loaded for any other writer.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 if_valid  in  1  fetch offers an entry.
REQ-008 if_ready  out  1  queue accepts an entry.
REQ-009 if_pc  in  32  fetched pc.
REQ-010 if_insn  in  32  fetched instruction.
REQ-011 if_exc  in  5  {ibus_fault, itlb_kmiss, itlb_umiss, itlb_invalid, itlb_priv}.
REQ-012 ex_stall  in  1  execute cannot accept; freeze outputs and scoreboard.
REQ-013 flush  in  1  discard queue and output slot.
REQ-014 ex_valid  out  1  output slot holds an issued instruction.
REQ-015 ex_pc, ex_insn  out  32 each  issued pc/instruction.
REQ-016 ex_exc  out  5  issued fetch exceptions; ex_illegal out 1 illegal opcode.
REQ-017 ex_rf_x_addr, ex_rf_y_addr, ex_rf_r_addr  out  5 each  register addresses.
REQ-018 ex_rf_r_we  out  1  result write enable; ex_imm out 32; ex_imm_sel out 1.
REQ-019 ex_op_load, ex_op_mul, ex_op_rrb  out  1 each  class flags (mul covers mul/div/rem, all variants).

Function
REQ-020 Queue: push when if_valid & if_ready; if_ready = !full only (no same-cycle pop bypass); FIFO order.
REQ-021 Head decoded combinationally with existing eco32f opcode encodings: x = 30 for RFX else insn[25:21]; y = insn[20:16]; r = insn[15:11] for RRR, 31 for JAL/JALR, else insn[20:16].
REQ-022 r_we set for RRR, RRS, RRI, LDHI, loads, JAL/JALR, MVFS; forced 0 when r = 0.
REQ-023 imm: zero-extended for RRI, {insn[15:0],16'h0} for LDHI, else sign-extended; imm_sel = !RRR & !RRB.
REQ-024 Illegal opcodes 6'h1e, 6'h3e, 6'h3f; issue normally with ex_illegal = 1.
REQ-025 Scoreboard: 32 counters, width clog2(max latency+1); register 0 never tracked, always ready.
REQ-026 On issue with r_we: counter[r] <= LAT_LOAD / LAT_MUL / LAT_ALU per class; all other nonzero counters decrement by 1 when !ex_stall.
REQ-027 Same-cycle issue and decrement on same register: load wins.
REQ-028 Source not ready: non-branch consumer if counter >= 2; branch (RRB) consumer if counter >= 1; only x/y actually used count (y unused for RRS/RRI/load/J/JAL).
REQ-029 Issue = head valid & all used sources ready & !ex_stall & !flush; pops head.
REQ-030 When !ex_stall: ex_valid <= issue; other ex_* loaded from head on issue, otherwise hold values (bubble marked by ex_valid = 0 only).
REQ-031 ex_stall: all ex_*, queue head and counters hold; pushes still accepted while not full.
REQ-032 flush (overrides ex_stall): queue emptied, same-cycle push dropped, ex_valid <= 0; counters unchanged.
REQ-033 Pointers wrap modulo DEPTH; full/empty via extra pointer bit.

Reset
REQ-034 On rst: queue empty, if_ready = 1, ex_valid = 0, all counters 0, all other ex_* = 0; takes effect without clock edge.

Verification
REQ-035 Reset, then 4 independent ADDs back-to-back -> ex_valid high 4 consecutive cycles, pcs in order, no bubble.
REQ-036 LDW r5; ADD r6,r5,r1 (defaults) -> exactly 1 bubble cycle (ex_valid = 0) between them.
REQ-037 MUL r7; BEQ r7,r0 (LAT_MUL = 3) -> 3 bubble cycles before BEQ issues.
REQ-038 DEPTH = 4, ex_stall held 6 cycles, fetch streaming -> if_ready low after 4 pushes; after release, all 4 issue in order, none lost or duplicated.
REQ-039 flush with queue holding 3 entries and if_valid high -> next cycle ex_valid = 0, queue empty, flushed pcs never issue.
REQ-040 Opcode 6'h3f at pc 0x100 with if_exc = 5'b00100 -> ex_illegal = 1, ex_exc = 5'b00100, ex_pc = 0x100; rst pulsed mid-stream -> outputs zero immediately.

Source files
------------

// File: rtl/eco32f_decode_sb.sv
// eco32f decode stage: fetch queue, head decode, 32-entry countdown scoreboard
// and a single registered issue slot toward execute.
module eco32f_decode_sb #(
   parameter int DEPTH    = 4,
   parameter int LAT_LOAD = 2,
   parameter int LAT_MUL  = 3,
   parameter int LAT_ALU  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_insn,
   input  logic [4:0]  if_exc,
   input  logic        ex_stall,
   input  logic        flush,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_insn,
   output logic [4:0]  ex_exc,
   output logic        ex_illegal,
   output logic [4:0]  ex_rf_x_addr,
   output logic [4:0]  ex_rf_y_addr,
   output logic [4:0]  ex_rf_r_addr,
   output logic        ex_rf_r_we,
   output logic [31:0] ex_imm,
   output logic        ex_imm_sel,
   output logic        ex_op_load,
   output logic        ex_op_mul,
   output logic        ex_op_rrb
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LAT_LM  = (LAT_LOAD > LAT_MUL) ? LAT_LOAD : LAT_MUL;
   localparam int LAT_MAX = (LAT_LM > LAT_ALU) ? LAT_LM : LAT_ALU;
   localparam int CW      = $clog2(LAT_MAX + 1);

   logic [31:0]   r_q_pc   [DEPTH];
   logic [31:0]   r_q_insn [DEPTH];
   logic [4:0]    r_q_exc  [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [CW-1:0] r_sb     [32];

   logic          w_empty, w_full, w_push, w_issue;
   logic [AW-1:0] w_head;
   logic [31:0]   w_insn;
   logic [5:0]    w_op;
   logic          w_rrr, w_rrs, w_rri, w_ldhi, w_rrb, w_j, w_jal, w_jalr;
   logic          w_trap, w_rfx, w_load, w_mvfs, w_mul, w_illegal;
   logic [4:0]    w_x, w_y, w_r;
   logic          w_we, w_x_used, w_y_used, w_x_wait, w_y_wait;
   logic [31:0]   w_imm;
   logic [CW-1:0] w_lat;
   logic [CW:0]   w_thr;

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign if_ready = !w_full;
   assign w_push   = if_valid && !w_full && !flush;
   assign w_head   = r_rd_ptr[AW-1:0];
   assign w_insn   = r_q_insn[w_head];
   assign w_op     = w_insn[31:26];

   // RRS = sign-extended immediate arithmetic, RRI = zero-extended immediate ops.
   assign w_rrr     = (w_op <= 6'h1c) && !w_op[0];
   assign w_rrs     = w_op inside {6'h01, 6'h03, 6'h05, 6'h09, 6'h0d};
   assign w_rri     = (w_op <= 6'h1d) && w_op[0] && !w_rrs;
   assign w_ldhi    = (w_op == 6'h1f);
   assign w_rrb     = w_op inside {[6'h20:6'h29]};
   assign w_j       = (w_op == 6'h2a);
   assign w_jal     = (w_op == 6'h2c);
   assign w_jalr    = (w_op == 6'h2d);
   assign w_trap    = (w_op == 6'h2e);
   assign w_rfx     = (w_op == 6'h2f);
   assign w_load    = w_op inside {[6'h30:6'h34]};
   assign w_mvfs    = (w_op == 6'h38);
   assign w_mul     = w_op inside {[6'h04:6'h0f]};
   assign w_illegal = w_op inside {6'h1e, 6'h3e, 6'h3f};

   assign w_x = w_rfx ? 5'd30 : w_insn[25:21];
   assign w_y = w_insn[20:16];
   assign w_r = w_rrr ? w_insn[15:11] : ((w_jal || w_jalr) ? 5'd31 : w_insn[20:16]);
   assign w_we = (w_rrr || w_rrs || w_rri || w_ldhi || w_load || w_jal || w_jalr || w_mvfs)
                 && (w_r != 5'd0);
   assign w_imm = w_rri  ? {16'h0000, w_insn[15:0]} :
                  w_ldhi ? {w_insn[15:0], 16'h0000} :
                           {{16{w_insn[15]}}, w_insn[15:0]};
   assign w_lat = w_load ? CW'(LAT_LOAD) : (w_mul ? CW'(LAT_MUL) : CW'(LAT_ALU));

   // Branches resolve in the first execute cycle, so they cannot use the ALU forward.
   assign w_x_used = !(w_j || w_jal || w_ldhi || w_trap || w_mvfs);
   assign w_y_used = !(w_rrs || w_rri || w_load || w_j || w_jal);
   assign w_thr    = w_rrb ? (CW+1)'(1) : (CW+1)'(2);
   assign w_x_wait = w_x_used && ({1'b0, r_sb[w_x]} >= w_thr);
   assign w_y_wait = w_y_used && ({1'b0, r_sb[w_y]} >= w_thr);
   assign w_issue  = !w_empty && !w_x_wait && !w_y_wait && !ex_stall && !flush;

   // NOTE: queue storage has no reset; only the pointers say which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr[AW-1:0]]   <= if_pc;
         r_q_insn[r_wr_ptr[AW-1:0]] <= if_insn;
         r_q_exc[r_wr_ptr[AW-1:0]]  <= if_exc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_issue) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Entry 0 is cleared on reset and never loaded, so r0 always reads ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_sb[i] <= '0;
      end else if (!ex_stall && !flush) begin
         for (int i = 1; i < 32; i++) begin
            if (w_issue && w_we && (w_r == 5'(i))) r_sb[i] <= w_lat;
            else if (r_sb[i] != '0)                r_sb[i] <= r_sb[i] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_insn      <= '0;
         ex_exc       <= '0;
         ex_illegal   <= 1'b0;
         ex_rf_x_addr <= '0;
         ex_rf_y_addr <= '0;
         ex_rf_r_addr <= '0;
         ex_rf_r_we   <= 1'b0;
         ex_imm       <= '0;
         ex_imm_sel   <= 1'b0;
         ex_op_load   <= 1'b0;
         ex_op_mul    <= 1'b0;
         ex_op_rrb    <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (!ex_stall) begin
         ex_valid <= w_issue;
         if (w_issue) begin
            ex_pc        <= r_q_pc[w_head];
            ex_insn      <= w_insn;
            ex_exc       <= r_q_exc[w_head];
            ex_illegal   <= w_illegal;
            ex_rf_x_addr <= w_x;
            ex_rf_y_addr <= w_y;
            ex_rf_r_addr <= w_r;
            ex_rf_r_we   <= w_we;
            ex_imm       <= w_imm;
            ex_imm_sel   <= !w_rrr && !w_rrb;
            ex_op_load   <= w_load;
            ex_op_mul    <= w_mul;
            ex_op_rrb    <= w_rrb;
         end
      end
   end

endmodule

// File: tb/tb_eco32f_decode_sb.sv
// Bench for eco32f_decode_sb: directed hazard/stall/flush scenarios plus a random
// stream, compared every cycle with a queue-and-countdown reference model.
module tb_eco32f_decode_sb;

   localparam int DEPTH    = 4;
   localparam int LAT_LOAD = 2;
   localparam int LAT_MUL  = 3;
   localparam int LAT_ALU  = 1;

   localparam int C_RRR = 0, C_RRS = 1, C_RRI = 2, C_LDHI = 3, C_BR = 4, C_J = 5,
                  C_JR = 6, C_JAL = 7, C_JALR = 8, C_TRAP = 9, C_RFX = 10, C_LOAD = 11,
                  C_STORE = 12, C_MVFS = 13, C_MVTS = 14, C_TLB = 15, C_ILL = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  exc;
   } fe_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  exc;
      logic        ill;
      logic [4:0]  xa;
      logic [4:0]  ya;
      logic [4:0]  ra;
      logic        we;
      logic [31:0] imm;
      logic        sel;
      logic        ld;
      logic        mul;
      logic        rrb;
   } ex_t;

   typedef struct {
      ex_t e;
      bit  xu;
      bit  yu;
      int  lat;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] if_pc = '0;
   logic [31:0] if_insn = '0;
   logic [4:0]  if_exc = '0;
   logic        ex_stall = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_insn, ex_imm;
   logic [4:0]  ex_exc, ex_rf_x_addr, ex_rf_y_addr, ex_rf_r_addr;
   logic        ex_illegal, ex_rf_r_we, ex_imm_sel, ex_op_load, ex_op_mul, ex_op_rrb;

   int checks = 0;
   int errors = 0;

   fe_t         fq[$];
   fe_t         mq[$];
   int          busy[32];
   bit          m_valid;
   ex_t         m_ex;
   bit          tr_valid[$];
   logic [31:0] tr_pc[$];
   int          n_push;
   logic [31:0] next_pc;

   eco32f_decode_sb #(
      .DEPTH(DEPTH), .LAT_LOAD(LAT_LOAD), .LAT_MUL(LAT_MUL), .LAT_ALU(LAT_ALU)
   ) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_insn(if_insn), .if_exc(if_exc),
      .ex_stall(ex_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_insn(ex_insn), .ex_exc(ex_exc), .ex_illegal(ex_illegal),
      .ex_rf_x_addr(ex_rf_x_addr), .ex_rf_y_addr(ex_rf_y_addr), .ex_rf_r_addr(ex_rf_r_addr),
      .ex_rf_r_we(ex_rf_r_we), .ex_imm(ex_imm), .ex_imm_sel(ex_imm_sel),
      .ex_op_load(ex_op_load), .ex_op_mul(ex_op_mul), .ex_op_rrb(ex_op_rrb)
   );

   always #5 clk = ~clk;

   function automatic ex_t dut_payload();
      return {ex_pc, ex_insn, ex_exc, ex_illegal, ex_rf_x_addr, ex_rf_y_addr, ex_rf_r_addr,
              ex_rf_r_we, ex_imm, ex_imm_sel, ex_op_load, ex_op_mul, ex_op_rrb};
   endfunction

   function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] r, logic [4:0] x, logic [4:0] y);
      return {op, x, y, r, 11'h000};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] r, logic [4:0] x, logic [15:0] imm);
      return {op, x, r, imm};
   endfunction

   // Reference decode: opcode table -> instruction class -> fields by the class rules.
   function automatic dec_t ref_decode(fe_t f);
      dec_t       d;
      int         cls;
      logic [5:0] op;
      op = f.insn[31:26];
      case (op)
         6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0a, 6'h0c, 6'h0e,
         6'h10, 6'h12, 6'h14, 6'h16, 6'h18, 6'h1a, 6'h1c:          cls = C_RRR;
         6'h01, 6'h03, 6'h05, 6'h09, 6'h0d:                        cls = C_RRS;
         6'h07, 6'h0b, 6'h0f, 6'h11, 6'h13, 6'h15, 6'h17, 6'h19,
         6'h1b, 6'h1d:                                             cls = C_RRI;
         6'h1f: cls = C_LDHI;
         6'h2a: cls = C_J;
         6'h2b: cls = C_JR;
         6'h2c: cls = C_JAL;
         6'h2d: cls = C_JALR;
         6'h2e: cls = C_TRAP;
         6'h2f: cls = C_RFX;
         6'h35, 6'h36, 6'h37: cls = C_STORE;
         6'h38: cls = C_MVFS;
         6'h39: cls = C_MVTS;
         6'h3a, 6'h3b, 6'h3c, 6'h3d: cls = C_TLB;
         6'h1e, 6'h3e, 6'h3f: cls = C_ILL;
         default: cls = (op >= 6'h30) ? C_LOAD : C_BR;
      endcase
      d.e.pc   = f.pc;
      d.e.insn = f.insn;
      d.e.exc  = f.exc;
      d.e.ill  = (cls == C_ILL);
      d.e.xa   = (cls == C_RFX) ? 5'd30 : f.insn[25:21];
      d.e.ya   = f.insn[20:16];
      if (cls == C_RRR)                        d.e.ra = f.insn[15:11];
      else if (cls == C_JAL || cls == C_JALR)  d.e.ra = 5'd31;
      else                                     d.e.ra = f.insn[20:16];
      d.e.we = (cls inside {C_RRR, C_RRS, C_RRI, C_LDHI, C_LOAD, C_JAL, C_JALR, C_MVFS})
               && (d.e.ra != 5'd0);
      if (cls == C_RRI)       d.e.imm = {16'h0, f.insn[15:0]};
      else if (cls == C_LDHI) d.e.imm = {f.insn[15:0], 16'h0};
      else                    d.e.imm = {{16{f.insn[15]}}, f.insn[15:0]};
      d.e.sel = !(cls == C_RRR || cls == C_BR);
      d.e.ld  = (cls == C_LOAD);
      d.e.mul = (op >= 6'h04 && op <= 6'h0f);
      d.e.rrb = (cls == C_BR);
      d.lat   = d.e.ld ? LAT_LOAD : (d.e.mul ? LAT_MUL : LAT_ALU);
      d.xu    = !(cls inside {C_J, C_JAL, C_LDHI, C_TRAP, C_MVFS});
      d.yu    = !(cls inside {C_RRS, C_RRI, C_LOAD, C_J, C_JAL});
      return d;
   endfunction

   function automatic int find_pc(logic [31:0] pc);
      for (int i = 0; i < tr_valid.size(); i++)
         if (tr_valid[i] && tr_pc[i] == pc) return i;
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      if_valid = 1'b0;
      ex_stall = 1'b0;
      flush = 1'b0;
      #1;
      checks++;
      if (ex_valid !== 1'b0 || dut_payload() !== '0 || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: ex_valid=%b payload=%h if_ready=%b, required 0/0/1",
                  ex_valid, dut_payload(), if_ready);
      end
      mq.delete();
      fq.delete();
      for (int i = 0; i < 32; i++) busy[i] = 0;
      m_valid = 1'b0;
      m_ex = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: present fq head, advance the model, compare all outputs after the edge.
   task automatic cycle(input bit stall, input bit fl, input bit gap);
      fe_t  f;
      dec_t d;
      bit   v, issue, push;
      int   thr;
      v = (fq.size() > 0) && !gap;
      f = v ? fq[0] : fe_t'({$urandom, $urandom, 5'($urandom)});
      if_valid = v;
      if_pc    = f.pc;
      if_insn  = f.insn;
      if_exc   = f.exc;
      ex_stall = stall;
      flush    = fl;
      #1;
      checks++;
      if (if_ready !== (mq.size() < DEPTH)) begin
         errors++;
         $display("FAIL if_ready: got %b, required %b (queue %0d)", if_ready, mq.size() < DEPTH, mq.size());
      end
      if (if_valid && if_ready && !fl) n_push++;
      push  = v && (mq.size() < DEPTH) && !fl;
      issue = 1'b0;
      if (mq.size() > 0 && !stall && !fl) begin
         d     = ref_decode(mq[0]);
         thr   = d.e.rrb ? 1 : 2;
         issue = !(d.xu && busy[d.e.xa] >= thr) && !(d.yu && busy[d.e.ya] >= thr);
      end
      if (fl) begin
         mq.delete();
         m_valid = 1'b0;
      end else if (!stall) begin
         for (int i = 0; i < 32; i++) if (busy[i] > 0) busy[i]--;
         m_valid = issue;
         if (issue) begin
            if (d.e.we) busy[d.e.ra] = d.lat;
            m_ex = d.e;
            void'(mq.pop_front());
         end
      end
      if (push) begin
         mq.push_back(f);
         void'(fq.pop_front());
      end
      @(posedge clk);
      #1;
      checks++;
      if (ex_valid !== m_valid) begin
         errors++;
         $display("FAIL ex_valid: got %b, required %b at %0t", ex_valid, m_valid, $time);
      end
      checks++;
      if (dut_payload() !== m_ex) begin
         errors++;
         $display("FAIL ex_payload: got %h, required %h at %0t", dut_payload(), m_ex, $time);
      end
      if (!stall && !fl) begin
         tr_valid.push_back(ex_valid);
         tr_pc.push_back(ex_pc);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      run(2);
   endtask

   task automatic test_back_to_back();
      int  i0;
      bit  ok;
      do_reset();
      tr_valid.delete(); tr_pc.delete();
      for (int k = 0; k < 4; k++)
         fq.push_back('{32'h10 + 32'(4*k), enc_r(6'h00, 5'(1+3*k), 5'(2+3*k), 5'(3+3*k)), 5'h0});
      run(10);
      i0 = find_pc(32'h10);
      ok = (i0 >= 0) && (i0 + 3 < tr_valid.size());
      if (ok)
         for (int k = 0; k < 4; k++)
            if (!tr_valid[i0+k] || tr_pc[i0+k] !== 32'h10 + 32'(4*k)) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL back_to_back: first issue index %0d, required 4 consecutive pcs 0x10..0x1c", i0);
      end
   endtask

   task automatic test_load_use();
      int a, b;
      do_reset();
      tr_valid.delete(); tr_pc.delete();
      fq.push_back('{32'h20, enc_i(6'h30, 5'd5, 5'd0, 16'h0004), 5'h0});
      fq.push_back('{32'h24, enc_r(6'h00, 5'd6, 5'd5, 5'd1), 5'h0});
      run(10);
      a = find_pc(32'h20);
      b = find_pc(32'h24);
      checks++;
      if (a < 0 || b - a != 2) begin
         errors++;
         $display("FAIL load_use: issue gap %0d (idx %0d,%0d), required 2 (one bubble)", b - a, a, b);
      end
   endtask

   task automatic test_mul_branch();
      int a, b;
      do_reset();
      tr_valid.delete(); tr_pc.delete();
      fq.push_back('{32'h30, enc_r(6'h04, 5'd7, 5'd1, 5'd2), 5'h0});
      fq.push_back('{32'h34, enc_i(6'h20, 5'd0, 5'd7, 16'h0010), 5'h0});
      run(12);
      a = find_pc(32'h30);
      b = find_pc(32'h34);
      checks++;
      if (a < 0 || b - a != 4) begin
         errors++;
         $display("FAIL mul_branch: issue gap %0d (idx %0d,%0d), required 4 (three bubbles)", b - a, a, b);
      end
   endtask

   task automatic test_stall_full();
      logic [31:0] got[$];
      bit          ok;
      do_reset();
      tr_valid.delete(); tr_pc.delete();
      n_push = 0;
      for (int k = 0; k < 6; k++)
         fq.push_back('{32'h40 + 32'(4*k), enc_r(6'h10, 5'(8+k), 5'd1, 5'd2), 5'h0});
      for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (n_push != 4 || if_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_full: pushes %0d if_ready %b, required 4 and 0", n_push, if_ready);
      end
      run(14);
      for (int i = 0; i < tr_valid.size(); i++) if (tr_valid[i]) got.push_back(tr_pc[i]);
      ok = (got.size() == 6);
      if (ok)
         for (int k = 0; k < 6; k++) if (got[k] !== 32'h40 + 32'(4*k)) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall_order: %0d issues seen, required 6 in order from 0x40", got.size());
      end
   endtask

   task automatic test_flush();
      bit seen;
      do_reset();
      fq.push_back('{32'h60, enc_r(6'h00, 5'd1, 5'd2, 5'd3), 5'h0});
      run(3);
      for (int k = 1; k <= 4; k++)
         fq.push_back('{32'h60 + 32'(4*k), enc_r(6'h12, 5'(10+k), 5'd4, 5'd5), 5'h0});
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_now: ex_valid %b if_ready %b, required 0 and 1", ex_valid, if_ready);
      end
      fq.delete();
      tr_valid.delete(); tr_pc.delete();
      run(6);
      seen = 1'b0;
      foreach (tr_valid[i]) if (tr_valid[i]) seen = 1'b1;
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_drop: a flushed entry issued, required none");
      end
   endtask

   task automatic test_illegal_and_reset();
      bit found;
      do_reset();
      fq.push_back('{32'h100, {6'h3f, 26'h2a5_5a5a}, 5'b00100});
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         cycle(1'b0, 1'b0, 1'b0);
         found = (ex_valid === 1'b1);
      end
      checks++;
      if (!found || ex_illegal !== 1'b1 || ex_exc !== 5'b00100 || ex_pc !== 32'h100) begin
         errors++;
         $display("FAIL illegal: seen %b ill %b exc %b pc %h, required 1 1 00100 00000100",
                  found, ex_illegal, ex_exc, ex_pc);
      end
      for (int k = 0; k < 4; k++)
         fq.push_back('{32'h200 + 32'(4*k), enc_i(6'h11, 5'(1+k), 5'd2, 16'h1234), 5'h0});
      run(3);
      do_reset();
      run(2);
   endtask

   task automatic test_random();
      fe_t f;
      do_reset();
      next_pc = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         if (fq.size() < 2) begin
            f.pc = next_pc;
            next_pc += 4;
            f.insn = $urandom;
            f.insn[25:21] = 5'($urandom_range(0, 7));
            f.insn[20:16] = 5'($urandom_range(0, 7));
            f.insn[15:11] = 5'($urandom_range(0, 7));
            f.exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            fq.push_back(f);
         end
         cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25);
         if (i == 1500) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_mul_branch();
      test_stall_full();
      test_flush();
      test_illegal_and_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
